// File: rtl/ddr_deserializer_pkg.sv
// Shared definitions for the DDR deserializer: width legality, counter sizing,
// and the bit order of the capture-stage sample pair.
package ddr_deserializer_pkg;

  localparam int unsigned PAIR_FIRST  = 1;
  localparam int unsigned PAIR_SECOND = 0;

  typedef enum logic [1:0] {
    ACC_HOLD,
    ACC_PAIR,
    ACC_SLIP
  } acc_mode_e;

  function automatic bit width_legal(input int unsigned dw);
    return (dw >= 4) && ((dw % 2) == 0);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/ddr_deserializer_obuf.sv
// Generic 2-entry valid/ready FIFO. The head register drives the output and
// keeps its last value when the FIFO drains.
module ddr_deserializer_obuf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  output logic         full
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            head <= push_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= push_data;
          end else if (pop) begin
            occ <= 2'd0;
          end else if (push) begin
            tail <= push_data;
            occ  <= 2'd2;
          end
        end
        2'd2: begin
          // A push into a full FIFO is only taken when a pop frees the head.
          if (pop) begin
            head <= tail;
            if (push) tail <= push_data;
            else      occ  <= 2'd1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

  assign out_data = head;
  assign out_vld  = (occ != 2'd0);
  assign full     = (occ == 2'd2);

endmodule

// File: rtl/ddr_deserializer.sv
// Assembles DDR sample pairs into MSB-first words with single-bit slip
// alignment, buffered on a valid/ready stream with sticky overflow.
module ddr_deserializer
  import ddr_deserializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            din,
  input  logic                  din_vld,
  input  logic                  bitslip,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_vld,
  input  logic                  dout_rd,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
  localparam int unsigned SR_W  = DATA_WIDTH + 1;

  generate
    if (!width_legal(DATA_WIDTH)) begin : g_bad_width
      $error("ddr_deserializer: DATA_WIDTH must be even and >= 4");
    end
  endgenerate

  acc_mode_e             mode;
  logic [SR_W-1:0]       sr;
  logic [SR_W-1:0]       sr_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_after;
  logic [CNT_W-1:0]      cnt_next;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  ovf_set;

  // Valid bits live in sr[cnt-1:0] with the oldest bit at the top, so a
  // completed word is always the DATA_WIDTH bits just below cnt_after.
  always_comb begin
    mode = ACC_HOLD;
    if (din_vld) mode = bitslip ? ACC_SLIP : ACC_PAIR;

    sr_next   = sr;
    cnt_after = cnt;
    unique case (mode)
      ACC_PAIR: begin
        sr_next   = {sr[SR_W-3:0], din[PAIR_FIRST], din[PAIR_SECOND]};
        cnt_after = cnt + CNT_W'(2);
      end
      ACC_SLIP: begin
        sr_next   = {sr[SR_W-2:0], din[PAIR_SECOND]};
        cnt_after = cnt + CNT_W'(1);
      end
      default: ;
    endcase

    word_done = (mode != ACC_HOLD) && (cnt_after >= CNT_W'(DATA_WIDTH));
    word      = (cnt_after == CNT_W'(DATA_WIDTH + 1)) ? sr_next[SR_W-1:1]
                                                      : sr_next[DATA_WIDTH-1:0];
    cnt_next  = word_done ? (cnt_after - CNT_W'(DATA_WIDTH)) : cnt_after;
  end

  assign pop     = dout_vld & dout_rd;
  assign push    = word_done & (~full | pop);
  assign ovf_set = word_done & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      sr  <= sr_next;
      cnt <= cnt_next;
      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  ddr_deserializer_obuf #(
    .W(DATA_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(word),
    .pop      (pop),
    .out_data (dout_data),
    .out_vld  (dout_vld),
    .full     (full)
  );

endmodule

// File: tb/tb_ddr_deserializer.sv
// Randomized and directed scoreboard bench for ddr_deserializer.
module tb_ddr_deserializer;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    din;
  logic          din_vld;
  logic          bitslip;
  logic [DW-1:0] dout_data;
  logic          dout_vld;
  logic          dout_rd;
  logic          overflow;
  logic          overflow_clr;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state: a plain bit stream, buffer occupancy, overflow flag.
  bit            bits_q[$];
  logic [DW-1:0] sb_q[$];
  int unsigned   m_occ = 0;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] last_word = '0;
  int unsigned   words_seen = 0;

  ddr_deserializer #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_vld     (din_vld),
    .bitslip     (bitslip),
    .dout_data   (dout_data),
    .dout_vld    (dout_vld),
    .dout_rd     (dout_rd),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    bits_q.delete();
    sb_q.delete();
    m_occ = 0;
    m_ovf = 1'b0;
  endfunction

  always @(posedge rst) model_clear();

  // Model: consumes inputs at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      bit            popped;
      bit            done;
      logic [DW-1:0] w;
      int unsigned   occ_before;
      done = 1'b0;
      w    = '0;
      if (din_vld) begin
        if (bitslip) bits_q.push_back(din[0]);
        else begin
          bits_q.push_back(din[1]);
          bits_q.push_back(din[0]);
        end
      end
      if (bits_q.size() >= DW) begin
        for (int i = 0; i < DW; i++) w = {w[DW-2:0], bits_q.pop_front()};
        done = 1'b1;
      end
      occ_before = m_occ;
      popped = dout_rd && (m_occ > 0);
      if (popped) m_occ--;
      if (done) begin
        if (occ_before == 2 && !popped) m_ovf = 1'b1;
        else begin
          sb_q.push_back(w);
          m_occ++;
        end
      end
      if (!(done && occ_before == 2 && !popped) && overflow_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: compares outputs at the falling edge, pops on transfers.
  always @(negedge clk) begin
    if (!rst) begin
      check("dout_vld", {31'd0, dout_vld}, {31'd0, sb_q.size() != 0});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (dout_vld && sb_q.size() != 0) begin
        check("dout_data", {24'd0, dout_data}, {24'd0, sb_q[0]});
        if (dout_rd) begin
          last_word = sb_q.pop_front();
          words_seen++;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [1:0] p,
                       input logic rd, input logic clr);
    @(posedge clk);
    #1;
    din_vld      = v;
    bitslip      = s;
    din          = p;
    dout_rd      = rd;
    overflow_clr = clr;
  endtask

  task automatic feed_word(input logic [DW-1:0] w, input logic rd);
    logic [DW-1:0] t;
    t = w;
    for (int i = 0; i < DW / 2; i++) begin
      drive(1'b1, 1'b0, t[DW-1 -: 2], rd, 1'b0);
      t = t << 2;
    end
  endtask

  task automatic idle(input int unsigned n, input logic rd);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, rd, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    din_vld = 1'b0; bitslip = 1'b0; dout_rd = 1'b1; overflow_clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned n0;
    rst = 1'b1; din = 2'b00; din_vld = 1'b0; bitslip = 1'b0;
    dout_rd = 1'b1; overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_vld", {31'd0, dout_vld}, 32'd0);
    check("reset_data", {24'd0, dout_data}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // Basic word.
    n0 = words_seen;
    feed_word(8'hB1, 1'b1);
    idle(2, 1'b1);
    check("basic_word", {24'd0, last_word}, 32'h0000_00B1);
    check("basic_count", words_seen - n0, 32'd1);

    // Bitslip on the first pair, then leftover bit becomes the next MSB.
    drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("slip_word1", {24'd0, last_word}, 32'h0000_0099);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("slip_word2", {24'd0, last_word}, 32'h0000_0099);
    do_reset();

    // Idle gaps with an ignored bitslip.
    drive(1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("gap_word", {24'd0, last_word}, 32'h0000_00B1);

    // Backpressure and overflow.
    feed_word(8'hB1, 1'b0);
    feed_word(8'h5A, 1'b0);
    feed_word(8'h3C, 1'b0);
    idle(1, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    n0 = words_seen;
    idle(4, 1'b1);
    check("drain_count", words_seen - n0, 32'd2);
    check("drain_last", {24'd0, last_word}, 32'h0000_005A);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // Full buffer with a pop on the completion cycle.
    n0 = words_seen;
    feed_word(8'hB1, 1'b0);
    feed_word(8'h5A, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(5, 1'b1);
    check("simpop_ovf", {31'd0, overflow}, 32'd0);
    check("simpop_count", words_seen - n0, 32'd3);
    check("simpop_last", {24'd0, last_word}, 32'h0000_003C);

    // Asynchronous reset mid-word.
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    idle(1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_vld", {31'd0, dout_vld}, 32'd0);
    check("async_data", {24'd0, dout_data}, 32'd0);
    check("async_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    feed_word(8'hB1, 1'b1);
    idle(2, 1'b1);
    check("post_reset_word", {24'd0, last_word}, 32'h0000_00B1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
    end
    idle(6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_deserializer.md
Name: ddr_deserializer

Overview:
- Downstream consumer of the double-data-rate capture register, whose 2-bit output holds one rising-edge and one falling-edge sample per clk cycle.
- Assembles the 2-bit pairs into DATA_WIDTH-bit words, MSB-first.
- Provides single-bit alignment (bitslip) and presents words on a valid/ready stream through a 2-entry output buffer, with sticky overflow reporting.

Parameters:
- DATA_WIDTH, 8, output word width; even, >= 4.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  2  sample pair from the DDR capture stage. din[1] = rising-edge sample (earlier in time); din[0] = falling-edge sample (later).
- din_vld  in  1  din is valid this cycle.
- bitslip  in  1  single-cycle pulse that drops one bit to shift word alignment.
- dout_data  out  DATA_WIDTH  assembled word; first-received bit at MSB.
- dout_vld  out  1  dout_data valid.
- dout_rd  in  1  consumer ready; a transfer occurs when dout_vld and dout_rd are both 1.
- overflow  out  1  sticky: a completed word was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (async, rst=1): bit count=0, shift register=0, buffer empty, dout_vld=0, dout_data=0, overflow=0. A reset mid-word discards the partial word.
- Accumulator: shift register DATA_WIDTH+1 bits wide; bit count cnt ranges 0..DATA_WIDTH+1.
- Normal accept (din_vld=1, bitslip=0): shift in din[1] then din[0]; cnt += 2.
- Slip accept (din_vld=1, bitslip=1): shift in din[0] only; din[1] is discarded; cnt += 1. Each pulse moves alignment by one bit.
- bitslip with din_vld=0 is ignored.
- din_vld=0: no state change in the accumulator.
- Word completion: when cnt_after >= DATA_WIDTH, the oldest DATA_WIDTH bits form a word and cnt becomes cnt_after - DATA_WIDTH.
  - The leftover bit (0 or 1) is retained as the MSB of the next word.
  - A leftover bit exists only after an odd number of slips.
- Latency: the word appears on dout_data with dout_vld=1 on the cycle after the clock edge that accepted its last bit, if the buffer was empty.
- Output buffer: 2-entry FIFO; the head drives dout_data/dout_vld.
  - Pop on dout_vld & dout_rd.
  - dout_data is stable while dout_vld=1 and dout_rd=0.
- Buffer full and word completes:
  - With a pop in the same cycle: the word is pushed and nothing is lost.
  - Without a pop: the word is dropped and overflow is set to 1. Accumulator state advances normally.
- overflow: stays 1 until overflow_clr=1. If set and clear occur in the same cycle, set wins.
- dout_data when the buffer is empty: holds its last value; it is don't-care to consumers.

Decomposition:
- Shared package:
  - DATA_WIDTH legality check (even, >= 4).
  - CNT_W = clog2(DATA_WIDTH+2).
  - Bit-order constants: PAIR_FIRST=1, PAIR_SECOND=0.
- One sub-module, ddr_deserializer_obuf: generic 2-entry valid/ready FIFO with full output and async active-high reset. Reusable by other stream stages.
- The accumulator and slip logic stay in the top module.

Test Plan:
- Basic word (DATA_WIDTH=8, dout_rd=1): din_vld=1 with pairs 10, 11, 00, 01 on 4 consecutive cycles -> dout_data=8'hB1, dout_vld=1 for exactly 1 cycle, on the cycle after the 4th pair.
- Bitslip: bitslip=1 on the first pair; pairs 11, 00, 11, 00, 11 -> one word 8'h99 after the 5th pair, cnt=1 with leftover bit 1. Continuing with pairs 00, 11, 00 -> word 8'hCC? no: leftover 1 then bits 0,0,1,1,0,0 is only 7 bits; the next word emits after the 4th further pair. Check the leftover bit lands at MSB.
- Idle gaps: the 4 pairs from the first scenario with din_vld=0 cycles interleaved, and bitslip=1 during a din_vld=0 cycle -> same 8'hB1, and no slip effect.
- Backpressure/overflow: dout_rd=0; feed words B1, 5A, 3C ->
  - overflow=1 after the 3rd word completes.
  - Then dout_rd=1 -> B1 then 5A on consecutive cycles, then dout_vld=0.
  - overflow_clr -> overflow=0.
- Simultaneous pop: buffer full, dout_rd=1 on the completion cycle of a 3rd word -> no overflow; three words delivered in order.
- Reset mid-word: 3 pairs accepted, rst pulsed asynchronously -> outputs take reset values immediately. The next 4 pairs 10, 11, 00, 01 -> 8'hB1 with no stale bits.
